// File: rtl/tictactoe_ai_engine.sv
// Sequential N x N tic-tac-toe move engine.
// Scores one cell per clock: win > block > centre > corner > other.
module tictactoe_ai_engine #(
  parameter int N = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N*N-1:0]           x_state,
  input  logic [N*N-1:0]           o_state,
  input  logic                     ai_is_x,
  output logic                     busy,
  output logic                     done,
  output logic [N*N-1:0]           move,
  output logic [$clog2(N*N)-1:0]   move_idx,
  output logic                     no_move,
  output logic                     illegal
);

  localparam int CELLS = N * N;
  localparam int IDXW  = $clog2(CELLS);
  localparam int RW    = $clog2(N);
  localparam bit ODD   = (N % 2) == 1;
  localparam logic [IDXW-1:0] LAST   = IDXW'(CELLS - 1);
  localparam logic [IDXW-1:0] CENTRE = IDXW'((CELLS - 1) / 2);
  localparam logic [RW-1:0]   EDGE   = RW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_e;

  state_e            state_q, state_d;
  logic [CELLS-1:0]  x_q, x_d, o_q, o_d;
  logic              aix_q, aix_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [RW-1:0]     row_q, row_d, col_q, col_d;
  logic              bv_q, bv_d;
  logic [2:0]        bs_q, bs_d;
  logic [IDXW-1:0]   bi_q, bi_d;
  logic              ill_q, ill_d;
  logic              done_q, done_d;
  logic [CELLS-1:0]  move_q, move_d;
  logic [IDXW-1:0]   midx_q, midx_d;
  logic              nm_q, nm_d;
  logic              il_q, il_d;

  // Cell-indexed views: bit i is cell i (row*N+col).
  logic [CELLS-1:0]  xc, oc, cur, rowm, colm, dgm, anm;
  logic [CELLS-1:0]  ai_t, op_t;
  logic              on_dg, on_an;
  logic              win, blk, empty, corner, centre;
  logic [2:0]        score;

  function automatic logic full(input logic [CELLS-1:0] m,
                                input logic [CELLS-1:0] k);
    return (m & k) == k;
  endfunction

  always_comb begin
    xc   = '0;
    oc   = '0;
    cur  = '0;
    rowm = '0;
    colm = '0;
    dgm  = '0;
    anm  = '0;
    for (int j = 0; j < CELLS; j++) begin
      xc[j]   = x_q[CELLS-1-j];
      oc[j]   = o_q[CELLS-1-j];
      cur[j]  = (j == int'(idx_q));
      rowm[j] = (j / N == int'(row_q));
      colm[j] = (j % N == int'(col_q));
      dgm[j]  = (j / N == j % N);
      anm[j]  = (j / N + j % N == N - 1);
    end
  end

  always_comb begin
    ai_t   = (aix_q ? xc : oc) | cur;
    op_t   = (aix_q ? oc : xc) | cur;
    on_dg  = row_q == col_q;
    on_an  = (int'(row_q) + int'(col_q)) == N - 1;
    win    = full(ai_t, rowm) || full(ai_t, colm) ||
             (on_dg && full(ai_t, dgm)) ||
             (on_an && full(ai_t, anm));
    blk    = full(op_t, rowm) || full(op_t, colm) ||
             (on_dg && full(op_t, dgm)) ||
             (on_an && full(op_t, anm));
    empty  = ((xc | oc) & cur) == '0;
    centre = ODD && (idx_q == CENTRE);
    corner = (row_q == '0 || row_q == EDGE) &&
             (col_q == '0 || col_q == EDGE);
    if (win)         score = 3'd4;
    else if (blk)    score = 3'd3;
    else if (centre) score = 3'd2;
    else if (corner) score = 3'd1;
    else             score = 3'd0;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    o_d     = o_q;
    aix_d   = aix_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    bv_d    = bv_q;
    bs_d    = bs_q;
    bi_d    = bi_q;
    ill_d   = ill_q;
    done_d  = 1'b0;
    move_d  = move_q;
    midx_d  = midx_q;
    nm_d    = nm_q;
    il_d    = il_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x_state;
          o_d     = o_state;
          aix_d   = ai_is_x;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if ((x_q & o_q) != '0) begin
          ill_d   = 1'b1;
          state_d = DONE;
        end else begin
          ill_d   = 1'b0;
          bv_d    = 1'b0;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (empty && (!bv_q || score > bs_q)) begin
          bv_d = 1'b1;
          bs_d = score;
          bi_d = idx_q;
        end
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
          if (col_q == EDGE) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
        il_d   = ill_q;
        nm_d   = !ill_q && !bv_q;
        midx_d = (ill_q || !bv_q) ? '0 : bi_q;
        for (int j = 0; j < CELLS; j++) begin
          move_d[CELLS-1-j] = bv_q && !ill_q && (j == int'(bi_q));
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      o_q     <= '0;
      aix_q   <= 1'b0;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      bv_q    <= 1'b0;
      bs_q    <= '0;
      bi_q    <= '0;
      ill_q   <= 1'b0;
      done_q  <= 1'b0;
      move_q  <= '0;
      midx_q  <= '0;
      nm_q    <= 1'b0;
      il_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      o_q     <= o_d;
      aix_q   <= aix_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bv_q    <= bv_d;
      bs_q    <= bs_d;
      bi_q    <= bi_d;
      ill_q   <= ill_d;
      done_q  <= done_d;
      move_q  <= move_d;
      midx_q  <= midx_d;
      nm_q    <= nm_d;
      il_q    <= il_d;
    end
  end

  assign busy     = (state_q == LOAD) || (state_q == SCAN);
  assign done     = done_q;
  assign move     = move_q;
  assign move_idx = midx_q;
  assign no_move  = nm_q;
  assign illegal  = il_q;

endmodule

// File: tb/tb_tictactoe_ai_engine.sv
// Directed bench for tictactoe_ai_engine: N=3 vector table plus
// hand-written restart, reset and N=4 sequences.
module tb_tictactoe_ai_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start3 = 1'b0;
  logic [8:0] x3 = '0, o3 = '0;
  logic       aix3 = 1'b1;
  logic       busy3, done3, nm3, il3;
  logic [8:0] move3;
  logic [3:0] idx3;

  logic        start4 = 1'b0;
  logic [15:0] x4 = '0, o4 = '0;
  logic        aix4 = 1'b1;
  logic        busy4, done4, nm4, il4;
  logic [15:0] move4;
  logic [3:0]  idx4;

  tictactoe_ai_engine #(.N(3)) u3 (
    .clk(clk), .rst(rst), .start(start3),
    .x_state(x3), .o_state(o3), .ai_is_x(aix3),
    .busy(busy3), .done(done3), .move(move3),
    .move_idx(idx3), .no_move(nm3), .illegal(il3)
  );

  tictactoe_ai_engine #(.N(4)) u4 (
    .clk(clk), .rst(rst), .start(start4),
    .x_state(x4), .o_state(o4), .ai_is_x(aix4),
    .busy(busy4), .done(done4), .move(move4),
    .move_idx(idx4), .no_move(nm4), .illegal(il4)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [8:0] x;
    logic [8:0] o;
    logic       aix;
    int         idx;
    logic [8:0] mv;
    logic       nm;
    logic       il;
    int         lat;
  } vec_t;

  vec_t tv[9];

  // Pulse start for one edge, scramble inputs, return cycles to done.
  task automatic run3(input logic [8:0] x, input logic [8:0] o,
                      input logic aix, output int lat, output logic b1);
    @(negedge clk);
    x3 = x; o3 = o; aix3 = aix; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    x3 = 9'h1ff; o3 = 9'h0aa; aix3 = ~aix;
    b1 = busy3;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done3) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    int   ndone;
    logic b1;

    tv[0] = '{9'b000000000, 9'b000000000, 1'b1, 4, 9'b000010000, 1'b0, 1'b0, 11};
    tv[1] = '{9'b110000000, 9'b000011000, 1'b1, 2, 9'b001000000, 1'b0, 1'b0, 11};
    tv[2] = '{9'b110000000, 9'b000010000, 1'b0, 2, 9'b001000000, 1'b0, 1'b0, 11};
    tv[3] = '{9'b101011010, 9'b010100101, 1'b1, 0, 9'b000000000, 1'b1, 1'b0, 11};
    tv[4] = '{9'b000010000, 9'b000010000, 1'b1, 0, 9'b000000000, 1'b0, 1'b1, 2};
    tv[5] = '{9'b000010000, 9'b000000000, 1'b1, 0, 9'b100000000, 1'b0, 1'b0, 11};
    tv[6] = '{9'b100010000, 9'b011000000, 1'b1, 8, 9'b000000001, 1'b0, 1'b0, 11};
    tv[7] = '{9'b100100000, 9'b000010000, 1'b0, 6, 9'b000000100, 1'b0, 1'b0, 11};
    tv[8] = '{9'b110000000, 9'b001010000, 1'b0, 6, 9'b000000100, 1'b0, 1'b0, 11};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy3, 0);
    chk("rst done", done3, 0);
    chk("rst move", move3, 0);
    chk("rst idx", idx3, 0);
    chk("rst no_move", nm3, 0);
    chk("rst illegal", il3, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run3(tv[i].x, tv[i].o, tv[i].aix, lat, b1);
      chk($sformatf("v%0d latency", i), lat, tv[i].lat);
      chk($sformatf("v%0d busy", i), b1, 1);
      chk($sformatf("v%0d move", i), move3, tv[i].mv);
      chk($sformatf("v%0d idx", i), idx3, tv[i].idx);
      chk($sformatf("v%0d illegal", i), il3, tv[i].il);
      if (!tv[i].il) chk($sformatf("v%0d no_move", i), nm3, tv[i].nm);
      @(posedge clk); #1;
      chk($sformatf("v%0d done pulse", i), done3, 0);
      chk($sformatf("v%0d hold idx", i), idx3, tv[i].idx);
    end

    // Second start mid-scan must be ignored
    @(negedge clk);
    x3 = 9'b110000000; o3 = 9'b000011000; aix3 = 1'b1; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0; x3 = '0; o3 = '0;
    repeat (4) @(posedge clk);
    #1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    lat = -1;
    ndone = 0;
    for (int c = 6; c <= 30; c++) begin
      @(posedge clk); #1;
      if (done3) begin
        ndone++;
        if (lat < 0) begin
          lat = c;
          chk("restart idx", idx3, 2);
          chk("restart move", move3, 9'b001000000);
        end
      end
    end
    chk("restart latency", lat, 11);
    chk("restart done count", ndone, 1);

    // Reset mid-scan clears outputs immediately
    @(negedge clk);
    x3 = '0; o3 = '0; aix3 = 1'b1; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst busy", busy3, 0);
    chk("midrst move", move3, 0);
    chk("midrst idx", idx3, 0);
    chk("midrst done", done3, 0);
    @(negedge clk);
    rst = 1'b0;
    run3(9'b000000000, 9'b000000000, 1'b1, lat, b1);
    chk("postrst latency", lat, 11);
    chk("postrst idx", idx3, 4);
    chk("postrst move", move3, 9'b000010000);

    // N=4 empty board: no centre, lowest corner wins
    @(negedge clk);
    x4 = '0; o4 = '0; aix4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done4) begin
        lat = c;
        break;
      end
    end
    chk("n4 latency", lat, 18);
    chk("n4 idx", idx4, 0);
    chk("n4 move", move4, 16'h8000);
    chk("n4 no_move", nm4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
